// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one outstanding program-memory fetch feeding an instruction register
// backed by a 1-deep prefetch buffer; taken jumps flush the buffer and squash in-flight fetches.
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                OPCODE_W = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Enable,
    output logic                MemReq,
    output logic [ADDR_W-1:0]   MemAddr,
    input  logic [INSTR_W-1:0]  MemData,
    input  logic                MemValid,
    input  logic                InstrDone,
    input  logic                JumpEn,
    input  logic [ADDR_W-1:0]   JumpAddr,
    output logic [OPCODE_W-1:0] OpCode,
    output logic [10:0]         IRData,
    output logic                IRValid,
    output logic                StepCounterReset,
    output logic [ADDR_W-1:0]   PC
);

    // state | meaning
    // IDLE  | no fetch outstanding
    // REQ   | MemReq high, waiting for the MemValid strobe
    typedef enum logic {IDLE, REQ} state_t;

    state_t               state;
    state_t               next_state;
    logic                 issue;
    logic [ADDR_W-1:0]    fetch_addr;
    logic                 squash;
    logic                 pb_valid;
    logic [INSTR_W-1:0]   pb_word;
    logic [ADDR_W-1:0]    pb_addr;
    logic                 retire;
    logic                 jump;
    logic                 mem_done;
    logic                 mem_keep;
    logic                 ir_free;

    assign retire   = InstrDone && IRValid;
    assign jump     = retire && JumpEn;
    assign mem_done = (state == REQ) && MemValid;
    // A returning word survives only if it was not squashed earlier and no jump lands on the same edge.
    assign mem_keep = mem_done && !squash && !jump;
    assign ir_free  = !IRValid || (retire && !JumpEn && !pb_valid);
    assign MemReq   = (state == REQ);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (Enable && (!IRValid || !pb_valid)) begin
                    next_state = REQ;
                    issue      = 1'b1;
                end
            end
            REQ: begin
                if (MemValid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            MemAddr          <= RESET_PC;
            fetch_addr       <= RESET_PC;
            squash           <= 1'b0;
            pb_valid         <= 1'b0;
            pb_word          <= '0;
            pb_addr          <= RESET_PC;
            OpCode           <= '0;
            IRData           <= '0;
            IRValid          <= 1'b0;
            StepCounterReset <= 1'b0;
            PC               <= RESET_PC;
        end else begin
            StepCounterReset <= 1'b0;

            // An issue on the jump edge goes straight to the target rather than the stale address.
            if (issue) begin
                MemAddr <= jump ? JumpAddr : fetch_addr;
            end

            if (jump) begin
                fetch_addr <= JumpAddr;
            end else if (mem_keep) begin
                fetch_addr <= fetch_addr + ADDR_W'(1);
            end

            if (mem_done && squash) begin
                squash <= 1'b0;
            end else if (jump && (state == REQ) && !MemValid) begin
                squash <= 1'b1;
            end

            if (mem_keep && ir_free) begin
                OpCode           <= MemData[INSTR_W-1 -: OPCODE_W];
                IRData           <= MemData[10:0];
                PC               <= MemAddr;
                IRValid          <= 1'b1;
                StepCounterReset <= 1'b1;
            end else if (jump) begin
                IRValid <= 1'b0;
            end else if (retire && pb_valid) begin
                OpCode           <= pb_word[INSTR_W-1 -: OPCODE_W];
                IRData           <= pb_word[10:0];
                PC               <= pb_addr;
                StepCounterReset <= 1'b1;
            end else if (retire) begin
                IRValid <= 1'b0;
            end

            if (jump) begin
                pb_valid <= 1'b0;
            end else if (mem_keep && !ir_free) begin
                pb_valid <= 1'b1;
                pb_word  <= MemData;
                pb_addr  <= MemAddr;
            end else if (retire && pb_valid) begin
                pb_valid <= 1'b0;
            end
        end
    end

endmodule
